booth_mult_seq: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier for the FFT butterfly datapath. It retires one Booth digit per clock, so a single adder and shifter replace one parallel partial-product unit per digit. It adds a runtime signed/unsigned mode and a valid/ready handshake on both sides, so it can sit between the twiddle ROM and the butterfly adders without external sequencing.

---
 rtl/booth_mult_seq_if.sv | 27 ++
 rtl/booth_mult_seq.sv | 126 ++++++++++++
 tb/tb_booth_mult_seq.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Handshake bundle for booth_mult_seq: operand side (in_*), result side
// (out_*), and the busy status flag.
interface booth_mult_seq_if #(
  parameter int WIDTH = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     mult_1;
  logic [WIDTH-1:0]     mult_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  // Producer / consumer side of the multiplier
  modport master (
    output in_valid, is_signed, mult_1, mult_2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // The multiplier itself
  modport slave (
    input  in_valid, is_signed, mult_1, mult_2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// CALC   | adding one Booth digit per cycle (N = WIDTH/2+1 digits)
// DONE   | result held with out_valid high until out_ready
//
// Operands are extended by two bits (sign or zero, by is_signed) so the
// same Booth recoding yields the exact product in both modes. Only the low
// 2*WIDTH bits of the accumulator reach the result, and addition modulo
// 2^(2*WIDTH) gives identical low bits, so the accumulator and the shifted
// multiplicand are kept at 2*WIDTH bits.
module booth_mult_seq #(
  parameter int WIDTH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mult_seq_if.slave bus
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [E-1:0]       m1_q, m1_d;
  logic               prev_q, prev_d;
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;

  logic [2:0]         trip;
  logic [2*WIDTH-1:0] pp;
  logic               ext1, ext2;

  // Booth digit decode: current multiplier pair plus the bit below it
  always_comb begin
    trip = {m1_q[1], m1_q[0], prev_q};
    pp   = '0;
    case (trip)
      3'b001, 3'b010: pp = mc_q;
      3'b011:         pp = mc_q << 1;
      3'b100:         pp = -(mc_q << 1);
      3'b101, 3'b110: pp = -mc_q;
      default:        pp = '0;
    endcase
  end

  // Next-state logic for the FSM and datapath registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m1_d    = m1_q;
    prev_d  = prev_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    ext1    = bus.is_signed & bus.mult_1[WIDTH-1];
    ext2    = bus.is_signed & bus.mult_2[WIDTH-1];
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m1_d    = {{2{ext1}}, bus.mult_1};
          mc_d    = {{WIDTH{ext2}}, bus.mult_2};
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_q + pp;
        // Shift instead of indexing: bits [1:0] always hold the live pair
        m1_d   = {2'b00, m1_q[E-1:2]};
        prev_d = m1_q[1];
        mc_d   = mc_q << 2;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m1_q    <= '0;
      prev_q  <= 1'b0;
      mc_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m1_q    <= m1_d;
      prev_q  <= prev_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = busy_q;
  assign bus.result    = acc_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=12.
module tb_booth_mult_seq;

  localparam int W  = 12;
  localparam int N  = W / 2 + 1;
  localparam int NB = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;
  int   t_acc = 0;

  logic [2*W-1:0] exp_q[$];

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[2*W-1:0];
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.mult_1    = a;
    bus.mult_2    = b;
    bus.is_signed = s;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vec++; err++;
      $display("FAIL issue_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk);
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    t_acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 100);
  endtask

  task automatic collect(output logic [2*W-1:0] got, output int lat, output bit ok);
    wait_valid(ok);
    lat = cyc - t_acc;
    got = bus.result;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.result} !== {1'b1, 1'b0, 1'b0, {2*W{1'b0}}}) begin
      err++;
      $display("FAIL reset_held: rdy/vld/busy/res=%b/%b/%b/%h, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.result} !== {1'b1, 1'b0, 1'b0, {2*W{1'b0}}}) begin
      err++;
      $display("FAIL reset_release: rdy/vld/busy/res=%b/%b/%b/%h, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[6] = '{12'h800, 12'h005, 12'h800, 12'hFFF, 12'h800, 12'hFFF};
    logic [W-1:0]   tb[6] = '{12'h800, 12'hFFD, 12'h7FF, 12'hFFF, 12'h003, 12'hFFF};
    logic           ts[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2*W-1:0] tr[6] = '{24'h400000, 24'hFFFFF1, 24'hC00800, 24'hFFE001, 24'h001800, 24'h000001};
    logic [2*W-1:0] got, exp_v;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      issue(ta[i], tb[i], ts[i]);
      vec++;
      if (bus.busy !== 1'b1) begin
        err++;
        $display("FAIL corner%0d_busy: busy=%b, required 1", i, bus.busy);
      end
      collect(got, lat, ok);
      exp_v = exp_q.pop_front();
      vec++;
      if (!ok || got !== tr[i]) begin
        err++;
        $display("FAIL corner%0d_result: got %h (valid seen=%0d), required %h", i, got, ok, tr[i]);
      end
      vec++;
      if (got !== exp_v) begin
        err++;
        $display("FAIL corner%0d_model: got %h, required %h", i, got, exp_v);
      end
      vec++;
      if (lat !== N) begin
        err++;
        $display("FAIL corner%0d_latency: %0d cycles, required %0d", i, lat, N);
      end
      vec++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        err++;
        $display("FAIL corner%0d_handshake: out_valid/in_ready=%b/%b, required 0/1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] held, exp_v;
    bit ok;
    issue(12'h123, 12'hE56, 1'b1);
    wait_valid(ok);
    held = bus.result;
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL bp_timeout: out_valid=%b, required 1", bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = (i % 2 == 0);
      bus.mult_1    = W'($urandom);
      bus.mult_2    = W'($urandom);
      bus.is_signed = 1'($urandom_range(0, 1));
      @(negedge clk);
      vec++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, held}) begin
        err++;
        $display("FAIL bp_hold%0d: vld/rdy/res=%b/%b/%h, required 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.result, held);
      end
    end
    bus.in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    vec++;
    if (held !== exp_v) begin
      err++;
      $display("FAIL bp_result: got %h, required %h", held, exp_v);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vec++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      err++;
      $display("FAIL bp_release: out_valid/in_ready=%b/%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    repeat (3) @(negedge clk);
    vec++;
    if ({bus.busy, bus.in_ready} !== 2'b01) begin
      err++;
      $display("FAIL bp_no_accept: busy/in_ready=%b/%b, required 0/1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_operand_change();
    logic [2*W-1:0] got, exp_v;
    int lat;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      issue(W'($urandom), W'($urandom), 1'(r % 2));
      for (int k = 0; k < N - 1; k++) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.mult_1    = W'($urandom);
        bus.mult_2    = W'($urandom);
        bus.is_signed = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      collect(got, lat, ok);
      exp_v = exp_q.pop_front();
      vec++;
      if (!ok || got !== exp_v) begin
        err++;
        $display("FAIL opchg%0d: got %h (valid seen=%0d), required %h", r, got, ok, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2*W-1:0] got, exp_v;
    int lat;
    bit ok;
    bit seen = 1'b0;
    issue(12'h0AB, 12'h0CD, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.result} !== {1'b1, 1'b0, 1'b0, {2*W{1'b0}}}) begin
      err++;
      $display("FAIL rst_mid: rdy/vld/busy/res=%b/%b/%b/%h, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    vec++;
    if (seen) begin
      err++;
      $display("FAIL rst_discard: out_valid seen=1, required 0");
    end
    issue(12'd7, 12'd9, 1'b0);
    collect(got, lat, ok);
    exp_v = exp_q.pop_front();
    vec++;
    if (!ok || got !== 24'd63 || exp_v !== 24'd63) begin
      err++;
      $display("FAIL rst_after: got %h, required %h", got, 24'd63);
    end
    vec++;
    if (lat !== N) begin
      err++;
      $display("FAIL rst_after_latency: %0d cycles, required %0d", lat, N);
    end
  endtask

  task automatic test_back_to_back();
    int got_n = 0;
    int idle = 0;
    int prev = -1000;
    logic [2*W-1:0] exp_v;
    fork
      begin
        for (int m = 0; m < 2; m++) begin
          for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'(m));
            vec++;
            if (t_acc - prev < N + 2) begin
              err++;
              $display("FAIL b2b_interval: %0d cycles, required >= %0d", t_acc - prev, N + 2);
            end
            prev = t_acc;
          end
        end
      end
      begin
        while (got_n < 2 * NB && idle < 1000) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vec++;
            if (exp_q.size() == 0) begin
              err++;
              $display("FAIL b2b_extra: result %h with empty scoreboard", bus.result);
            end else begin
              exp_v = exp_q.pop_front();
              if (bus.result !== exp_v) begin
                err++;
                $display("FAIL b2b_result%0d: got %h, required %h", got_n, bus.result, exp_v);
              end
            end
            got_n++;
            idle = 0;
          end else begin
            idle++;
          end
        end
        bus.out_ready = 1'b0;
      end
    join
    vec++;
    if (got_n != 2 * NB || exp_q.size() != 0) begin
      err++;
      $display("FAIL b2b_count: %0d results, %0d pending, required %0d and 0",
               got_n, exp_q.size(), 2 * NB);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.mult_1    = '0;
    bus.mult_2    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_corners();
    test_backpressure();
    test_operand_change();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
